// File: rtl/error_history_pkg.sv
// error_history_pkg: shared widths and types for the error history block.
// Optional difference path controlled by macro ERROR_HISTORY_DIFF_EN.
package error_history_pkg;

  localparam int SAMPLE_W_DEFAULT = 8;

  // Signed error sample at the default ADC width.
  typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

  // Each tap stores one raw sample.
  function automatic int tap_w(input int adc_w);
    return adc_w;
  endfunction

  // Channel select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Fill counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // First difference needs one guard bit.
  function automatic int d1_w(input int adc_w);
    return adc_w + 1;
  endfunction

  // Second difference spans +/-4*max, so two guard bits.
  function automatic int d2_w(input int adc_w);
    return adc_w + 2;
  endfunction

endpackage

// File: rtl/error_history_lane.sv
// error_history_lane: one channel's tap chain plus saturating fill counter.
// Exposes the post-edge (next) state so the top can register results
// in the same cycle the sample is accepted.
module error_history_lane
  import error_history_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_shift,
  input  logic                                  i_clear,
  input  logic [tap_w(ADC_WIDTH)-1:0]           i_sample,
  output logic [DEPTH-1:0][tap_w(ADC_WIDTH)-1:0] o_taps_nxt,
  output logic                                  o_full_nxt
);

  localparam int TW    = tap_w(ADC_WIDTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0][TW-1:0] r_taps;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;

  // Next state: clear first, then a shift loads the sample on top of it.
  always_comb begin
    o_taps_nxt = r_taps;
    w_cnt_nxt  = r_cnt;
    if (i_clear) begin
      o_taps_nxt = '0;
      w_cnt_nxt  = '0;
    end
    if (i_shift) begin
      o_taps_nxt = {o_taps_nxt[DEPTH-2:0], i_sample};
      if (w_cnt_nxt != CNT_W'(DEPTH))
        w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
    end
    o_full_nxt = (w_cnt_nxt == CNT_W'(DEPTH));
  end

  // History and fill counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taps <= '0;
      r_cnt  <= '0;
    end else begin
      r_taps <= o_taps_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/error_history.sv
// error_history: per-channel error sample history with registered taps and
// optional first/second differences (enabled by ERROR_HISTORY_DIFF_EN; when
// undefined d1/d2 are tied to zero).
module error_history
  import error_history_pkg::*;
#(
  parameter  int ADC_WIDTH = 8,
  parameter  int DEPTH     = 4,
  parameter  int NUM_CH    = 2,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int D1_W      = d1_w(ADC_WIDTH),
  localparam int D2_W      = d2_w(ADC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_valid,
  input  logic [CH_W-1:0]      err_ch,
  input  logic [ADC_WIDTH-1:0] err_in,
  input  logic [NUM_CH-1:0]    ch_clear,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic [ADC_WIDTH-1:0] e_new,
  output logic [ADC_WIDTH-1:0] e_prev,
  output logic [ADC_WIDTH-1:0] e_prev2,
  output logic [ADC_WIDTH-1:0] e_old,
  output logic [D1_W-1:0]      d1,
  output logic [D2_W-1:0]      d2,
  output logic                 hist_full
);

  localparam int TW = tap_w(ADC_WIDTH);

  logic [NUM_CH-1:0]                   w_shift;
  logic [NUM_CH-1:0][DEPTH-1:0][TW-1:0] w_taps_nxt;
  logic [NUM_CH-1:0]                   w_full_nxt;
  logic [DEPTH-1:0][TW-1:0]            w_sel_taps;
  logic                                w_sel_full;
  logic                                w_accept;

  logic                 r_out_valid;
  logic [CH_W-1:0]      r_out_ch;
  logic [TW-1:0]        r_e_new, r_e_prev, r_e_prev2, r_e_old;
  logic                 r_full;

  // Decode the target lane and pick its post-shift view; out-of-range
  // channels match no lane and are silently dropped.
  always_comb begin
    w_shift    = '0;
    w_sel_taps = '0;
    w_sel_full = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (err_valid && (err_ch == CH_W'(c))) begin
        w_shift[c] = 1'b1;
        w_sel_taps = w_taps_nxt[c];
        w_sel_full = w_full_nxt[c];
      end
    end
  end

  assign w_accept = |w_shift;

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_lane
    error_history_lane #(
      .ADC_WIDTH (ADC_WIDTH),
      .DEPTH     (DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_shift    (w_shift[g]),
      .i_clear    (ch_clear[g]),
      .i_sample   (err_in),
      .o_taps_nxt (w_taps_nxt[g]),
      .o_full_nxt (w_full_nxt[g])
    );
  end

  // Result register: strobe every accept, data held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_e_new     <= '0;
      r_e_prev    <= '0;
      r_e_prev2   <= '0;
      r_e_old     <= '0;
      r_full      <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_ch  <= err_ch;
        r_e_new   <= w_sel_taps[0];
        r_e_prev  <= w_sel_taps[1];
        r_e_prev2 <= w_sel_taps[2];
        r_e_old   <= w_sel_taps[DEPTH-1];
        r_full    <= w_sel_full;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign e_new     = r_e_new;
  assign e_prev    = r_e_prev;
  assign e_prev2   = r_e_prev2;
  assign e_old     = r_e_old;
  assign hist_full = r_full;

`ifdef ERROR_HISTORY_DIFF_EN
  logic [D1_W-1:0] w_d1, r_d1;
  logic [D2_W-1:0] w_d2, r_d2;
  logic [TW-1:0]   w_n, w_p, w_pp;

  assign w_n  = w_sel_taps[0];
  assign w_p  = w_sel_taps[1];
  assign w_pp = w_sel_taps[2];

  // Sign-extend before arithmetic; the guard bits make overflow impossible.
  assign w_d1 = {w_n[TW-1], w_n} - {w_p[TW-1], w_p};
  assign w_d2 = {{2{w_n[TW-1]}}, w_n} - {w_p[TW-1], w_p, 1'b0}
              + {{2{w_pp[TW-1]}}, w_pp};

  // Differences registered alongside the taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else if (w_accept) begin
      r_d1 <= w_d1;
      r_d2 <= w_d2;
    end
  end

  assign d1 = r_d1;
  assign d2 = r_d2;
`else
  assign d1 = '0;
  assign d2 = '0;
`endif

endmodule

// File: tb/tb_error_history.sv
// tb_error_history: directed checks for error_history. Expected d1/d2 follow
// ERROR_HISTORY_DIFF_EN (zero when the macro is undefined).
module tb_error_history;
  import error_history_pkg::*;

`ifdef ERROR_HISTORY_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       err_valid;
  logic [0:0] err_ch;
  logic [7:0] err_in;
  logic [1:0] ch_clear;
  logic       out_valid;
  logic [0:0] out_ch;
  logic [7:0] e_new, e_prev, e_prev2, e_old;
  logic [8:0] d1;
  logic [9:0] d2;
  logic       hist_full;

  // Second instance with a 2-bit channel select so an out-of-range
  // channel (3 with NUM_CH=3) can be presented.
  logic       b_valid;
  logic [1:0] b_ch;
  logic [2:0] b_clear;
  logic       b_out_valid;
  logic [1:0] b_out_ch;
  logic [7:0] b_e_new, b_e_prev, b_e_prev2, b_e_old;
  logic [8:0] b_d1;
  logic [9:0] b_d2;
  logic       b_full;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  error_history #(.ADC_WIDTH(8), .DEPTH(4), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .err_valid(err_valid), .err_ch(err_ch),
    .err_in(err_in), .ch_clear(ch_clear), .out_valid(out_valid),
    .out_ch(out_ch), .e_new(e_new), .e_prev(e_prev), .e_prev2(e_prev2),
    .e_old(e_old), .d1(d1), .d2(d2), .hist_full(hist_full)
  );

  error_history #(.ADC_WIDTH(8), .DEPTH(4), .NUM_CH(3)) dut_b (
    .clk(clk), .rst(rst), .err_valid(b_valid), .err_ch(b_ch),
    .err_in(err_in), .ch_clear(b_clear), .out_valid(b_out_valid),
    .out_ch(b_out_ch), .e_new(b_e_new), .e_prev(b_e_prev),
    .e_prev2(b_e_prev2), .e_old(b_e_old), .d1(b_d1), .d2(b_d2),
    .hist_full(b_full)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dx(input int v);
    return DIFF ? v : 0;
  endfunction

  // Present one cycle of inputs to dut, then return 1ns after the edge.
  task automatic step(input logic v, input int ch, input int val,
                      input logic [1:0] clr);
    logic [31:0] t_ch, t_val;
    t_ch = ch; t_val = val;
    err_valid = v;
    err_ch    = t_ch[0:0];
    err_in    = t_val[7:0];
    ch_clear  = clr;
    @(posedge clk); #1;
    err_valid = 1'b0;
    ch_clear  = '0;
  endtask

  task automatic chk_taps(input string tag, input int n, input int p,
                          input int pp, input int f);
    chk({tag, ".vld"},   {31'd0, out_valid}, 1);
    chk({tag, ".new"},   $signed(e_new),  n);
    chk({tag, ".prev"},  $signed(e_prev), p);
    chk({tag, ".prev2"}, $signed(e_prev2), pp);
    chk({tag, ".full"},  {31'd0, hist_full}, f);
    chk({tag, ".d1"},    $signed(d1), dx(n - p));
    chk({tag, ".d2"},    $signed(d2), dx(n - 2*p + pp));
  endtask

  initial begin
    rst = 1'b1; err_valid = 1'b0; err_ch = '0; err_in = '0; ch_clear = '0;
    b_valid = 1'b0; b_ch = '0; b_clear = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld",  {31'd0, out_valid}, 0);
    chk("rst.new",  $signed(e_new), 0);
    chk("rst.d1",   $signed(d1), 0);
    chk("rst.d2",   $signed(d2), 0);
    chk("rst.full", {31'd0, hist_full}, 0);
    chk("rst.ch",   {31'd0, out_ch}, 0);
    rst = 1'b0;

    // Basic fill of ch0: 10, 20, 5, 7
    step(1, 0, 10, 2'b00); chk_taps("s1", 10, 0, 0, 0);
    step(1, 0, 20, 2'b00); chk_taps("s2", 20, 10, 0, 0);
    step(1, 0, 5, 2'b00);  chk_taps("s3", 5, 20, 10, 0);
    step(1, 0, 7, 2'b00);  chk_taps("s4", 7, 5, 20, 1);
    chk("s4.old", $signed(e_old), 10);
    // Idle cycle: strobe drops, data holds
    step(0, 0, 99, 2'b00);
    chk("idle.vld", {31'd0, out_valid}, 0);
    chk("idle.new", $signed(e_new), 7);
    // Clear alone: no strobe, outputs held
    step(0, 0, 0, 2'b01);
    chk("clr.vld", {31'd0, out_valid}, 0);
    chk("clr.old", $signed(e_old), 10);

    // Extremes: -128 then 127 -> d1=255, d2=383
    step(1, 0, -128, 2'b00); chk_taps("ext1", -128, 0, 0, 0);
    step(1, 0, 127, 2'b00);  chk_taps("ext2", 127, -128, 0, 0);

    // Interleaved channels back to back
    step(1, 0, 1, 2'b00);   chk_taps("alt0", 1, 127, -128, 0);
    chk("alt0.ch", {31'd0, out_ch}, 0);
    step(1, 1, 100, 2'b00); chk_taps("alt1", 100, 0, 0, 0);
    chk("alt1.ch", {31'd0, out_ch}, 1);
    step(1, 0, 2, 2'b00);   chk_taps("alt2", 2, 1, 127, 1);
    chk("alt2.ch", {31'd0, out_ch}, 0);
    step(1, 1, 50, 2'b00);  chk_taps("alt3", 50, 100, 0, 0);

    // Clear and sample same channel same cycle
    step(1, 0, 9, 2'b01); chk_taps("cs", 9, 0, 0, 0);
    chk("cs.old", $signed(e_old), 0);

    // Reset mid-stream with a sample presented
    rst = 1'b1;
    step(1, 0, 55, 2'b00);
    rst = 1'b0;
    chk("mrst.vld",  {31'd0, out_valid}, 0);
    chk("mrst.new",  $signed(e_new), 0);
    chk("mrst.prev", $signed(e_prev), 0);
    chk("mrst.d1",   $signed(d1), 0);
    chk("mrst.full", {31'd0, hist_full}, 0);
    step(1, 0, 4, 2'b00); chk_taps("post", 4, 0, 0, 0);

    // Out-of-range channel on the 3-channel instance
    b_valid = 1'b1; b_ch = 2'd2; err_in = 8'd11;
    @(posedge clk); #1;
    chk("oor.v1", {31'd0, b_out_valid}, 1);
    chk("oor.n1", $signed(b_e_new), 11);
    b_ch = 2'd3; err_in = 8'd77;
    @(posedge clk); #1;
    chk("oor.v2", {31'd0, b_out_valid}, 0);
    chk("oor.n2", $signed(b_e_new), 11);
    b_ch = 2'd2; err_in = 8'd12;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("oor.v3", {31'd0, b_out_valid}, 1);
    chk("oor.n3", $signed(b_e_new), 12);
    chk("oor.p3", $signed(b_e_prev), 11);
    chk("oor.c3", {30'd0, b_out_ch}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
